// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: state encoding and shared widths for the spi_arbiter transaction controller.
package spi_arb_pkg;

  // Index width covers the largest supported requester count (16).
  localparam int NREQ_MAX = 16;
  localparam int IDXW     = $clog2(NREQ_MAX);
  localparam int GAPW     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_LO,
    ST_BUSY,
    ST_DONE,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// rr_pick: combinational winner search over req, starting at ptr_i and wrapping modulo NREQ.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  int cand;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    // Walk from the farthest candidate back to ptr so the nearest requester overwrites last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if ((req_i & (NREQ'(1) << cand)) != '0) begin
        idx_o   = IDXW'(cand);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between NREQ requesters; round-robin by default,
// fixed lowest-index priority when SPI_ARB_PRIO_EN is defined.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SIZE = 8,
  parameter int GAP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_tx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [SIZE-1:0]      rx_data,
  output logic [NREQ-1:0]      cs_n,
  output logic                 m_start,
  output logic [SIZE-1:0]      m_tx,
  input  logic                 m_ss,
  input  logic [SIZE-1:0]      m_rx
);

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [GAPW-1:0] gap_cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] cs_n_q;
  logic            m_start_q;
  logic [SIZE-1:0] m_tx_q;
  logic [SIZE-1:0] rx_data_q;

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] win_idx;
  logic            win_valid;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

`ifdef SPI_ARB_PRIO_EN
  assign ptr = '0;
`else
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_d;

  assign ptr_d = IDXW'((int'(win_idx) + 1) % NREQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (state_q == ST_IDLE && win_valid) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      cs_n_q    <= '1;
      m_start_q <= 1'b0;
      m_tx_q    <= '0;
      rx_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            idx_q     <= win_idx;
            m_tx_q    <= SIZE'(req_tx >> (int'(win_idx) * SIZE));
            gnt_q     <= NREQ'(1) << win_idx;
            cs_n_q    <= ~(NREQ'(1) << win_idx);
            m_start_q <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          m_start_q <= 1'b0;
          state_q   <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!m_ss) state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          // Strobe and data land together on the edge that enters DONE.
          if (m_ss) begin
            done_q    <= NREQ'(1) << idx_q;
            rx_data_q <= m_rx;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q    <= '0;
          gnt_q     <= '0;
          cs_n_q    <= '1;
          gap_cnt_q <= '0;
          state_q   <= (GAP == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAPW'(GAP - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAPW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign cs_n    = cs_n_q;
  assign m_start = m_start_q;
  assign m_tx    = m_tx_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench; the bench plays the SPI master (drives m_ss / m_rx).
module tb_spi_arbiter;

  localparam int NREQ = 4;
  localparam int SIZE = 8;
  localparam int GAP  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*SIZE-1:0] req_tx;
  logic [NREQ-1:0]      gnt, done, cs_n;
  logic [SIZE-1:0]      rx_data, m_tx;
  logic                 m_start;
  logic                 m_ss = 1'b1;
  logic [SIZE-1:0]      m_rx = '0;

  logic [SIZE-1:0] tx_word [NREQ] = '{8'h96, 8'h5A, 8'hA5, 8'hD3};
  logic [NREQ-1:0] all_ones = '1;

`ifdef SPI_ARB_PRIO_EN
  int wrap_second = 0;
  int cont_seq [5] = '{0, 0, 0, 0, 0};
`else
  int wrap_second = 1;
  int cont_seq [5] = '{0, 1, 2, 3, 0};
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_done_cyc  = 0;
  int last_start_cyc = 0;

  spi_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .GAP(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_tx  (req_tx),
    .gnt     (gnt),
    .done    (done),
    .rx_data (rx_data),
    .cs_n    (cs_n),
    .m_start (m_start),
    .m_tx    (m_tx),
    .m_ss    (m_ss),
    .m_rx    (m_rx)
  );

  assign req_tx = {tx_word[3], tx_word[2], tx_word[1], tx_word[0]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    m_ss = 1'b1;
    req  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = m_start;
    end
    check("start_seen", {31'b0, seen}, 32'd1);
  endtask

  // One full transfer as seen by the master; req is changed to req_after during BUSY.
  task automatic serve(input int idx, input logic [NREQ-1:0] req_after, input logic [SIZE-1:0] rx_val);
    bit seen;
    logic [NREQ-1:0] oh, oh_n;
    oh   = NREQ'(1) << idx;
    oh_n = ~oh;
    wait_start(seen);
    if (!seen) return;
    last_start_cyc = cyc;
    check("gnt", gnt, oh);
    check("cs_n_start", cs_n, oh_n);
    check("m_tx", m_tx, tx_word[idx]);
    @(posedge clk);
    #1 m_ss = 1'b0;
    @(negedge clk);
    check("m_start_one_cycle", m_start, 0);
    req = req_after;
    repeat (3) @(negedge clk);
    check("cs_n_busy", cs_n, oh_n);
    @(posedge clk);
    #1 m_ss = 1'b1;
    m_rx = rx_val;
    @(negedge clk);
    check("done_not_yet", done, 0);
    @(negedge clk);
    last_done_cyc = cyc;
    check("done_pulse", done, oh);
    check("rx_data", rx_data, rx_val);
    check("cs_n_done", cs_n, oh_n);
    check("m_tx_hold", m_tx, tx_word[idx]);
    @(negedge clk);
    check("done_clear", done, 0);
    check("cs_n_release", cs_n, all_ones);
    check("gnt_clear", gnt, 0);
  endtask

  initial begin
    bit seen;
    int prev_done;
    int bad;

    // Reset values and idle behaviour
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_cs_n", cs_n, all_ones);
    check("rst_m_start", m_start, 0);
    check("rst_m_tx", m_tx, 0);
    check("rst_rx_data", rx_data, 0);
    repeat (3) @(negedge clk);
    check("idle_no_start", m_start, 0);

    // Single request from requester 2
    req = 4'b0100;
    serve(2, 4'b0000, 8'h3C);
    repeat (2) @(negedge clk);
    check("rx_data_held", rx_data, 8'h3C);

    // Wrap: pointer is 3 after granting 2
    req = 4'b0011;
    serve(0, 4'b0011, 8'h11);
    serve(wrap_second, 4'b0000, 8'h22);

    // Reset asserted mid-BUSY
    req = 4'b1000;
    wait_start(seen);
    check("pre_rst_gnt", gnt, 4'b1000);
    @(posedge clk);
    #1 m_ss = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_cs_n", cs_n, all_ones);
    check("arst_m_start", m_start, 0);
    check("arst_m_tx", m_tx, 0);
    check("arst_rx_data", rx_data, 0);
    check("arst_done", done, 0);
    m_ss = 1'b1;
    req  = '0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0010;
    serve(1, 4'b0000, 8'h7E);

    // Contention with all requests held, from a fresh pointer
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      prev_done = last_done_cyc;
      serve(cont_seq[i], (i == 4) ? 4'b0000 : 4'b1111, SIZE'(8'h40 + i));
      if (i > 0) check("gap_spacing", last_start_cyc - prev_done, GAP + 2);
    end

    // Request dropped during BUSY
    req = 4'b0010;
    serve(1, 4'b0000, 8'hC4);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_start || gnt != '0) bad++;
    end
    check("no_regrant", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
